// File: rtl/pipe_defs.sv
// Shared pipeline definitions: hazard timing codes, register numbers, HI/LO FSM encoding.
// Pure declarations, no logic and no latency.
// No flow control here.
package pipe_defs;

  // A Tuse of 3 means the operand is never read.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Writes to $0 are discarded, so $0 never carries a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default HI/LO unit latencies and counter width.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A D-stage source is hazardous when a later-stage producer writes the same
  // non-zero register and its result arrives after D needs the operand.
  function automatic logic reg_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] dst,
                                      input logic [1:0] tnew);
    return (src != REG_ZERO) && (tuse != TUSE_NONE) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline decode/stage registers and the hazard controller.
// Wires only, zero latency.
// Stall outputs are the only flow control; no handshake of its own.
interface hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [1:0]       tuse_rs_D;
  logic [1:0]       tuse_rt_D;
  logic [4:0]       a3_E;
  logic [1:0]       tnew_E;
  logic [4:0]       a3_M;
  logic [1:0]       tnew_M;
  logic             md_use_D;
  logic             md_start_E;
  logic             md_is_div_E;
  logic             stall_PC;
  logic             stall_FD;
  logic             bubble_DE;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;

  // Pipeline side: supplies decode/stage info, consumes stall controls.
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_E, tnew_E, a3_M, tnew_M,
           md_use_D, md_start_E, md_is_div_E,
    input  stall_PC, stall_FD, bubble_DE, md_busy, md_cnt
  );

  // Hazard controller side.
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_E, tnew_E, a3_M, tnew_M,
           md_use_D, md_start_E, md_is_div_E,
    output stall_PC, stall_FD, bubble_DE, md_busy, md_cnt
  );
endinterface

// File: rtl/md_busy_fsm.sv
// HI/LO multiply/divide busy tracker: IDLE/BUSY FSM with a down-counter.
// Busy asserts the cycle after the start edge and lasts exactly N cycles.
// Starts arriving while busy are ignored; the pipeline stall prevents them.
module md_busy_fsm
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  // Latencies must be non-zero and fit in the counter.
  if (MULT_CYCLES < 1 || MULT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_mult
    $error("md_busy_fsm: MULT_CYCLES out of range for CNT_W");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > (1 << CNT_W) - 1) begin : g_bad_div
    $error("md_busy_fsm: DIV_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Next-state: load on start from IDLE, count down in BUSY, leave on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == MD_IDLE) begin
      if (md_start) begin
        state_d = MD_BUSY;
        cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
        busy_d  = 1'b1;
      end
    end else begin
      if (cnt_q == CNT_ONE) begin
        state_d = MD_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q - CNT_ONE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign md_busy = busy_q;
  assign md_cnt  = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew data hazards plus HI/LO busy interlock.
// Stall outputs are combinational (zero latency); HI/LO state is registered.
// One stall drives PC hold, F/D hold and D/E bubble together.
module hazard_ctrl
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic         CLK,
  input  logic         Reset,
  hazard_ctrl_if.slave bus
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;
  logic md_busy;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_fsm (
    .clk       (CLK),
    .rst_n     (Reset),
    .md_start  (bus.md_start_E),
    .md_is_div (bus.md_is_div_E),
    .md_busy   (md_busy),
    .md_cnt    (bus.md_cnt)
  );

  // Compare D sources against E/M destinations and fold in the HI/LO interlock.
  always_comb begin
    stall_rs = reg_hazard(bus.rs_D, bus.tuse_rs_D, bus.a3_E, bus.tnew_E) ||
               reg_hazard(bus.rs_D, bus.tuse_rs_D, bus.a3_M, bus.tnew_M);
    stall_rt = reg_hazard(bus.rt_D, bus.tuse_rt_D, bus.a3_E, bus.tnew_E) ||
               reg_hazard(bus.rt_D, bus.tuse_rt_D, bus.a3_M, bus.tnew_M);
    // A start in E counts as busy so the next HI/LO user is held immediately.
    stall_md = bus.md_use_D && (md_busy || bus.md_start_E);
    stall    = stall_rs | stall_rt | stall_md;
  end

  assign bus.stall_PC  = stall;
  assign bus.stall_FD  = stall;
  assign bus.bubble_DE = stall;
  assign bus.md_busy   = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipe_defs::*;

  logic CLK = 1'b0;
  logic Reset = 1'b0;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       stall;
    logic       busy;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   passed = 0;
  int   illegal_seen = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic drv(input logic rst,
                     input logic [4:0] rs, input logic [1:0] trs,
                     input logic [4:0] rt, input logic [1:0] trt,
                     input logic [4:0] a3e, input logic [1:0] tne,
                     input logic [4:0] a3m, input logic [1:0] tnm,
                     input logic use_md, input logic st, input logic dv);
    @(posedge CLK);
    #1;
    Reset           = rst;
    bus.rs_D        = rs;
    bus.tuse_rs_D   = trs;
    bus.rt_D        = rt;
    bus.tuse_rt_D   = trt;
    bus.a3_E        = a3e;
    bus.tnew_E      = tne;
    bus.a3_M        = a3m;
    bus.tnew_M      = tnm;
    bus.md_use_D    = use_md;
    bus.md_start_E  = st;
    bus.md_is_div_E = dv;
  endtask

  task automatic md(input logic rst, input logic use_md, input logic st, input logic dv);
    drv(rst, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, use_md, st, dv);
  endtask

  task automatic expect_out(input string nm, input logic s, input logic b, input logic [3:0] c);
    exp_t x;
    x.name  = nm;
    x.stall = s;
    x.busy  = b;
    x.cnt   = c;
    sb.push_back(x);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (bus.md_start_E === 1'b1 && bus.md_busy === 1'b1) begin
      illegal_seen++;
      $display("assert: md_start_E while HI/LO busy (md_cnt=%0d) at %0t", bus.md_cnt, $time);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, "/stall"}, {5'd0, bus.stall_PC, bus.stall_FD, bus.bubble_DE}, {5'd0, {3{e.stall}}});
      chk({e.name, "/busy"}, {7'd0, bus.md_busy}, {7'd0, e.busy});
      chk({e.name, "/cnt"}, {4'd0, bus.md_cnt}, {4'd0, e.cnt});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    bus.rs_D = 5'd0; bus.tuse_rs_D = TUSE_NONE; bus.rt_D = 5'd0; bus.tuse_rt_D = TUSE_NONE;
    bus.a3_E = 5'd0; bus.tnew_E = 2'd0; bus.a3_M = 5'd0; bus.tnew_M = 2'd0;
    bus.md_use_D = 1'b0; bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b0;

    // Reset held with a start pending: unit must stay idle.
    md(1'b0, 1'b0, 1'b1, 1'b0); expect_out("rst1", 1'b0, 1'b0, 4'd0);
    md(1'b0, 1'b0, 1'b1, 1'b0); expect_out("rst2", 1'b0, 1'b0, 4'd0);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("rel", 1'b0, 1'b0, 4'd0);

    // rs hazards.
    drv(1'b1, 5'd5, 2'd0, 5'd0, TUSE_NONE, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_out("rs_E", 1'b1, 1'b0, 4'd0);
    drv(1'b1, 5'd5, 2'd0, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_out("rs_M_ready", 1'b0, 1'b0, 4'd0);
    drv(1'b1, 5'd5, 2'd1, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_out("rs_M_late", 1'b1, 1'b0, 4'd0);
    drv(1'b1, 5'd5, 2'd1, 5'd0, TUSE_NONE, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_out("rs_tuse_eq_tnew", 1'b0, 1'b0, 4'd0);

    // rt hazards, $0 exemption, unused operand.
    drv(1'b1, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_out("rt_zero", 1'b0, 1'b0, 4'd0);
    drv(1'b1, 5'd0, TUSE_NONE, 5'd8, 2'd0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_out("rt_E", 1'b1, 1'b0, 4'd0);
    drv(1'b1, 5'd0, TUSE_NONE, 5'd8, TUSE_NONE, 5'd8, 2'd2, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_out("rt_unused", 1'b0, 1'b0, 4'd0);
    drv(1'b1, 5'd9, 2'd1, 5'd8, 2'd0, 5'd3, 2'd2, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_out("rt_M", 1'b1, 1'b0, 4'd0);

    // Multiply: 5 busy cycles, HI/LO user stalled from the start cycle on.
    md(1'b1, 1'b1, 1'b1, 1'b0); expect_out("mul_start", 1'b1, 1'b0, 4'd0);
    for (int k = 5; k >= 1; k--) begin
      md(1'b1, 1'b1, 1'b0, 1'b0); expect_out("mul_busy", 1'b1, 1'b1, 4'(k));
    end
    md(1'b1, 1'b1, 1'b0, 1'b0); expect_out("mul_done", 1'b0, 1'b0, 4'd0);

    // Divide aborted by reset at count 6.
    md(1'b1, 1'b0, 1'b1, 1'b1); expect_out("div_start", 1'b0, 1'b0, 4'd0);
    for (int k = 10; k >= 7; k--) begin
      md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("div_busy", 1'b0, 1'b1, 4'(k));
    end
    md(1'b0, 1'b1, 1'b0, 1'b0); expect_out("div_cnt6", 1'b1, 1'b1, 4'd6);
    md(1'b1, 1'b1, 1'b0, 1'b0); expect_out("div_abort", 1'b0, 1'b0, 4'd0);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("post_abort", 1'b0, 1'b0, 4'd0);

    // Starts while busy (mid-count and on the final cycle) are ignored.
    md(1'b1, 1'b0, 1'b1, 1'b0); expect_out("rs_start", 1'b0, 1'b0, 4'd0);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("rs_busy5", 1'b0, 1'b1, 4'd5);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("rs_busy4", 1'b0, 1'b1, 4'd4);
    md(1'b1, 1'b0, 1'b1, 1'b1); expect_out("rs_pulse3", 1'b0, 1'b1, 4'd3);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("rs_busy2", 1'b0, 1'b1, 4'd2);
    md(1'b1, 1'b0, 1'b1, 1'b1); expect_out("rs_pulse1", 1'b0, 1'b1, 4'd1);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("rs_end", 1'b0, 1'b0, 4'd0);
    md(1'b1, 1'b0, 1'b0, 1'b0); expect_out("rs_idle", 1'b0, 1'b0, 4'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", sb.size());

    chk("illegal_start_assert", 8'(illegal_seen), 8'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
